// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, state encoding and result payload.
// The state encoding is common to the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_e;

  localparam parity_e PARITY_TYPE = PARITY_EVEN;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } uart_state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } rx_result_t;

  // Parity bit a correct frame carries for the given data byte
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
    return (^data) ^ 1'(PARITY_TYPE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clock-enable generator: one-cycle tick every DIVISOR clk1 cycles.
// While i_clear is high the counter is held at zero, so phase restarts on release.
module uart_baud_tick #(
  parameter int unsigned DIVISOR = 27
) (
  input  logic clk1,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick_c
);

  localparam int unsigned DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_wrap;

  assign w_wrap   = (r_div_cnt == DIV_W'(DIVISOR - 1));
  assign o_tick_c = w_wrap & ~i_clear;

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (i_clear || w_wrap) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8 data bits LSB-first, even parity, one stop bit.
// Samples the synchronized line at mid-bit; presents each byte with a one-cycle strobe.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR    = 27,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = 3;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [TICK_W-1:0]    w_tick_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par_bit;
  logic                 w_par_bit_nxt;
  rx_result_t           r_result;
  rx_result_t           w_result_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_busy;
  logic                 w_tick;
  logic                 w_half;
  logic                 w_full;

  // Tick phase is cleared while idle so it aligns to the detected start edge
  uart_baud_tick #(
    .DIVISOR (DIVISOR)
  ) u_baud_tick (
    .clk1     (clk1),
    .rst      (rst),
    .i_clear  (r_state == ST_IDLE),
    .o_tick_c (w_tick)
  );

  assign w_half = (r_tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
  assign w_full = (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_bit_nxt  = r_par_bit;
    w_result_nxt   = r_result;
    w_valid_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tick_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          if (w_half) begin
            w_tick_cnt_nxt = '0;
            if (r_rx_s) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt   = ST_DATA;
              w_bit_cnt_nxt = '0;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (w_full) begin
            w_tick_cnt_nxt         = '0;
            w_shift_nxt[r_bit_cnt] = r_rx_s;
            if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) w_state_nxt = ST_PARITY;
            else w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          if (w_full) begin
            w_tick_cnt_nxt = '0;
            w_par_bit_nxt  = r_rx_s;
            w_state_nxt    = ST_STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_full) begin
            w_tick_cnt_nxt          = '0;
            w_result_nxt.data       = r_shift;
            w_result_nxt.parity_err = r_par_bit ^ calc_parity(r_shift);
            w_result_nxt.frame_err  = ~r_rx_s;
            w_valid_nxt             = 1'b1;
            w_state_nxt             = ST_IDLE;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_tick_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_s     <= r_rx_meta;
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_result   <= w_result_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rx_data    = r_result.data;
  assign parity_err = r_result.parity_err;
  assign frame_err  = r_result.frame_err;
  assign rx_valid   = r_valid;
  assign busy       = r_busy;

endmodule
